// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // Writes to this index are accepted but never reach the register file.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // One writeback request: destination index plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] reg_idx;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. On contention the requester that did not win
// the previous transfer is chosen. The remembered winner only moves on a transfer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_last_grant;

    // One-hot grant from the current valids and the previous winner.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner of each completed transfer; reset favours requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (advance) begin
            r_last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the ALU writeback (requester 0)
// and the load/multi-cycle unit (requester 1). The winning request is
// registered onto the write port. Read indices that match the registered
// write are flagged for forwarding.
module regfile_wr_arbiter
    import regfile_pkg::wr_req_t;
    import regfile_pkg::REG_ZERO;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              fwd1,
    output logic              fwd2,
    output logic [DATA_W-1:0] fwd_data
);

    logic [1:0]        w_valid;
    logic [1:0]        w_grant;
    logic [1:0]        w_ready;
    logic              w_xfer;
    wr_req_t           w_req [2];
    wr_req_t           w_sel;
    logic [ADDR_W-1:0] w_rd [2];
    logic [1:0]        w_fwd;

    logic              r_regwrite;
    logic [ADDR_W-1:0] r_wr_reg;
    logic [DATA_W-1:0] r_wr_data;

    assign w_valid  = {req1_valid, req0_valid};
    assign w_req[0] = '{reg_idx: req0_reg, data: req0_data};
    assign w_req[1] = '{reg_idx: req1_reg, data: req1_data};
    assign w_rd[0]  = rd_reg1;
    assign w_rd[1]  = rd_reg2;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (w_valid),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    // Ready is the grant, masked during reset so nothing transfers then.
    // Forward flags compare each read index against the held write.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign w_ready[gi] = w_grant[gi] & ~rst;
            assign w_fwd[gi]   = r_regwrite && (w_rd[gi] == r_wr_reg);
        end
    endgenerate

    assign w_xfer = |w_ready;
    assign w_sel  = w_grant[1] ? w_req[1] : w_req[0];

    // Write-port register: load the winner, suppress the enable for register 0,
    // and hold index/data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_wr_reg   <= '0;
            r_wr_data  <= '0;
        end else if (w_xfer) begin
            r_regwrite <= (w_sel.reg_idx != REG_ZERO);
            r_wr_reg   <= w_sel.reg_idx;
            r_wr_data  <= w_sel.data;
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign RegWrite   = r_regwrite;
    assign wr_reg     = r_wr_reg;
    assign wr_data    = r_wr_data;
    assign fwd1       = w_fwd[0];
    assign fwd2       = w_fwd[1];
    assign fwd_data   = r_wr_data;

endmodule
